// File: rtl/kronos_sram_arbiter.sv
// Round-robin arbiter merging the Kronos fetch and load/store buses onto one
// single-port SRAM; returns a registered one-cycle ack per master.
module kronos_sram_arbiter #(
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rstz,
  input  logic [AWIDTH-1:0] instr_addr,
  output logic [31:0]       instr_data,
  input  logic              instr_req,
  output logic              instr_ack,
  input  logic [AWIDTH-1:0] data_addr,
  output logic [31:0]       data_rd_data,
  input  logic [31:0]       data_wr_data,
  input  logic [3:0]        data_mask,
  input  logic              data_wr_en,
  input  logic              data_req,
  output logic              data_ack,
  output logic [AWIDTH-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_en,
  output logic              sram_wr_en,
  output logic [3:0]        sram_mask
);

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  grant_e last_q, last_d;
  logic   instr_ack_q, data_ack_q;
  logic   elig_i, elig_d;
  logic   grant_i, grant_d;

  // A port in its ack cycle is not eligible, so a still-held request is not
  // serviced twice; grants are suppressed entirely while in reset.
  always_comb begin
    elig_i  = instr_req & ~instr_ack_q;
    elig_d  = data_req & ~data_ack_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rstz) begin
      if (elig_i && elig_d) begin
        if (last_q == GNT_INSTR) grant_d = 1'b1;
        else                     grant_i = 1'b1;
      end else begin
        grant_i = elig_i;
        grant_d = elig_d;
      end
    end
    last_d = last_q;
    if (grant_i)      last_d = GNT_INSTR;
    else if (grant_d) last_d = GNT_DATA;
  end

  always_ff @(posedge clk) begin
    if (!rstz) begin
      last_q      <= GNT_INSTR;
      instr_ack_q <= 1'b0;
      data_ack_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      instr_ack_q <= grant_i;
      data_ack_q  <= grant_d;
    end
  end

  always_comb begin
    sram_en    = grant_i | grant_d;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wr_en = 1'b0;
    sram_mask  = 4'b0000;
    if (grant_i) begin
      sram_addr = instr_addr;
    end else if (grant_d) begin
      sram_addr  = data_addr;
      sram_wdata = data_wr_data;
      sram_wr_en = data_wr_en;
      sram_mask  = data_wr_en ? data_mask : 4'b0000;
    end
  end

  // SRAM read data always belongs to the previous cycle's access.
  assign instr_data   = sram_rdata;
  assign data_rd_data = sram_rdata;
  assign instr_ack    = instr_ack_q;
  assign data_ack     = data_ack_q;

endmodule

// File: tb/tb_kronos_sram_arbiter.sv
// Self-checking bench: SRAM behavioural model plus a cycle-level reference
// of the arbitration rules with a shadow memory for expected read data.
module tb_kronos_sram_arbiter;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] instr_addr, instr_data;
  logic        instr_req, instr_ack;
  logic [31:0] data_addr, data_rd_data, data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en, data_req, data_ack;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_en, sram_wr_en;
  logic [3:0]  sram_mask;

  always #5 clk = ~clk;

  kronos_sram_arbiter #(.AWIDTH(32)) dut (
    .clk(clk), .rstz(rstz),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .instr_req(instr_req), .instr_ack(instr_ack),
    .data_addr(data_addr), .data_rd_data(data_rd_data),
    .data_wr_data(data_wr_data), .data_mask(data_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_en(sram_en), .sram_wr_en(sram_wr_en), .sram_mask(sram_mask)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (i * 32'h0100_0193);
  endfunction

  // SRAM model: 16K words, one-cycle read latency, byte-masked writes.
  logic [31:0] sram_mem [0:16383];
  bit          sram_ready;
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 16384; i++) sram_mem[i] <= init_word(i);
      sram_ready <= 1'b1;
    end else if (sram_en) begin
      if (sram_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (sram_mask[b]) sram_mem[sram_addr[15:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr[15:2]];
      end
    end
  end

  // Reference state
  logic [31:0] ref_mem [0:16383];
  int          checks = 0, failures = 0;
  int          mode = 0;        // 0 directed, 1 random, 2 continuous
  bit          prev_data = 0;   // last serviced port was data
  bit          pend_i = 0, pend_d = 0, m_ack_i = 0, m_ack_d = 0;
  bit          d_load_n = 0, d_load = 0;
  logic [31:0] exp_idata_n, exp_ddata_n, exp_idata, exp_ddata;
  int          n_access = 0, n_double = 0;
  bit          prev_iack_obs = 0, prev_dack_obs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic rand_instr();
    instr_addr = $urandom & 32'hFFFF_013F;
  endtask

  task automatic rand_data();
    data_addr    = $urandom & 32'hFFFF_013F;
    data_wr_en   = $urandom_range(0, 1);
    data_mask    = 4'($urandom);
    data_wr_data = $urandom;
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    m_ack_i   = pend_i;
    m_ack_d   = pend_d;
    exp_idata = exp_idata_n;
    exp_ddata = exp_ddata_n;
    d_load    = d_load_n;
    chk("instr_ack", instr_ack, m_ack_i);
    chk("data_ack", data_ack, m_ack_d);
    if (m_ack_i) chk("instr_data", instr_data, exp_idata);
    if (m_ack_d && d_load) chk("data_rd_data", data_rd_data, exp_ddata);
    if (mode == 2) begin
      if ((instr_ack && prev_iack_obs) || (data_ack && prev_dack_obs)) n_double++;
    end
    prev_iack_obs = instr_ack;
    prev_dack_obs = data_ack;
  endtask

  task automatic step_begin();
    tick_check();
    case (mode)
      1: begin
        if (!instr_req || m_ack_i) begin
          instr_req = ($urandom_range(0, 3) != 0);
          rand_instr();
        end
        if (!data_req || m_ack_d) begin
          data_req = ($urandom_range(0, 3) != 0);
          rand_data();
        end
      end
      2: begin
        if (m_ack_i) rand_instr();
        if (m_ack_d) rand_data();
      end
      default: begin
        if (m_ack_i) instr_req = 1'b0;
        if (m_ack_d) data_req = 1'b0;
      end
    endcase
  endtask

  // Applies the arbitration rules to the settled inputs of this cycle.
  task automatic eval();
    bit gi, gd, ei, ed;
    int idx;
    #1;
    gi = 0; gd = 0;
    if (rstz) begin
      ei = instr_req && !m_ack_i;
      ed = data_req && !m_ack_d;
      if (ei && ed) begin
        if (prev_data) gi = 1; else gd = 1;
      end else begin
        gi = ei; gd = ed;
      end
    end
    chk("sram_en", sram_en, gi | gd);
    if (gi) begin
      chk("sram_addr_i", sram_addr, instr_addr);
      chk("sram_wr_en_i", sram_wr_en, 0);
      chk("sram_mask_i", sram_mask, 0);
      chk("sram_wdata_i", sram_wdata, 0);
      exp_idata_n = ref_mem[instr_addr[15:2]];
      prev_data = 0;
    end
    if (gd) begin
      idx = int'(data_addr[15:2]);
      chk("sram_addr_d", sram_addr, data_addr);
      chk("sram_wr_en_d", sram_wr_en, data_wr_en);
      chk("sram_mask_d", sram_mask, data_wr_en ? data_mask : 4'b0000);
      chk("sram_wdata_d", sram_wdata, data_wr_data);
      if (data_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (data_mask[b]) ref_mem[idx][b*8 +: 8] = data_wr_data[b*8 +: 8];
      end else begin
        exp_ddata_n = ref_mem[idx];
      end
      d_load_n = !data_wr_en;
      prev_data = 1;
    end
    if (!rstz) prev_data = 0;
    pend_i = gi;
    pend_d = gd;
    if (gi || gd) n_access++;
  endtask

  task automatic cyc();
    step_begin();
    eval();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
    rstz = 0; instr_req = 0; data_req = 0;
    instr_addr = 0; data_addr = 0; data_wr_data = 0; data_mask = 0; data_wr_en = 0;
    cyc();
    cyc();
    step_begin(); rstz = 1; eval();

    // Lone fetch from 0x100
    step_begin(); instr_req = 1; instr_addr = 32'h100; eval();
    cyc();
    cyc();

    // Partial store then load of 0x40
    step_begin();
    data_req = 1; data_addr = 32'h40; data_wr_data = 32'hDEADBEEF;
    data_mask = 4'b0011; data_wr_en = 1;
    eval();
    step_begin(); data_req = 1; data_wr_en = 0; data_mask = 4'b1111; eval();
    cyc();
    step_begin();
    chk("ld_lo", data_rd_data[15:0], 16'hBEEF);
    chk("ld_hi", data_rd_data[31:16], init_word(32'h40 >> 2) >> 16);
    eval();

    // Reset, then simultaneous first requests: data wins
    step_begin(); rstz = 0; eval();
    step_begin();
    rstz = 1;
    instr_req = 1; instr_addr = 32'h200;
    data_req = 1; data_addr = 32'h300; data_wr_en = 0;
    eval();
    chk("first_conflict_data", sram_addr, 32'h300);
    repeat (3) cyc();

    // Load ack overlapping an instr grant
    step_begin(); data_req = 1; data_addr = 32'h0; data_wr_en = 0; eval();
    step_begin(); instr_req = 1; instr_addr = 32'h80; eval();
    chk("ld_vs_instr", data_rd_data, ref_mem[0]);
    repeat (2) cyc();

    // Reset asserted in the data grant cycle
    step_begin(); data_req = 1; data_addr = 32'h44; data_wr_en = 0; rstz = 0; eval();
    step_begin(); chk("rst_no_ack", data_ack, 0); rstz = 1; eval();
    repeat (2) cyc();

    // Continuous dual requests for 10 cycles
    mode = 2;
    step_begin();
    instr_req = 1; data_req = 1; rand_instr(); rand_data();
    n_access = 0; n_double = 0;
    eval();
    repeat (9) cyc();
    chk("alt_count", n_access, 10);
    chk("no_double_ack", n_double, 0);
    mode = 0;
    step_begin(); instr_req = 0; data_req = 0; eval();
    cyc();

    // Random traffic
    mode = 1;
    repeat (400) cyc();
    mode = 0;
    step_begin(); instr_req = 0; data_req = 0; eval();
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
